imem_loadable: RTL and testbench

Parametrised, synchronous-read instruction memory for the CPU fetch stage, with a sequential program-load port. It replaces a fixed, combinationally-read ROM. Memory contents can be rewritten at run time from a loader (UART/debug bridge) without re-synthesis. Fetch uses a one-cycle-latency req/valid handshake; a small FSM locks out fetch while a program image is streamed in.

---
 rtl/imem_loadable.sv | 115 +++++++++++
 tb/tb_imem_loadable.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_loadable.sv
// Synchronous-read instruction memory with a 1-cycle fetch req/valid handshake
// and a sequential program-load port that locks out fetch while an image streams in.
module imem_loadable #(
  parameter int               ADDR_W    = 10,
  parameter int               DATA_W    = 32,
  parameter int               DEPTH     = 1 << ADDR_W,
  parameter int               BYTE_ADDR = 0,
  parameter logic [DATA_W-1:0] NOP_WORD = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              fetch_req,
  input  logic [ADDR_W+1:0] fetch_addr,
  output logic              fetch_ready,
  output logic              fetch_valid,
  output logic [DATA_W-1:0] fetch_data,
  output logic              fetch_err,
  input  logic              ld_start,
  input  logic [ADDR_W:0]   ld_len,
  input  logic              ld_valid,
  input  logic [DATA_W-1:0] ld_data,
  output logic              ld_ready,
  output logic              ld_done
);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DONE} state_t;

  localparam logic [ADDR_W:0] DEPTH_W = (ADDR_W+1)'(DEPTH);

  state_t            state, next_state;
  logic [ADDR_W:0]   len_q, wptr_q, len_clamped;
  logic              wr_en;
  logic              fetch_acc, misaligned, out_of_range, fetch_bad;
  logic [ADDR_W-1:0] fetch_idx;
  logic [DATA_W-1:0] mem [DEPTH];

  assign len_clamped = (ld_len > DEPTH_W) ? DEPTH_W : ld_len;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of its neighbours.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= next_state;
  end

  // NOTE: every output of this block gets a default first, so no path can
  // leave a variable unassigned and infer a latch.
  always_comb begin
    next_state = state;
    wr_en      = 1'b0;
    unique case (state)
      S_IDLE: if (ld_start) next_state = (len_clamped == '0) ? S_DONE : S_LOAD;
      S_LOAD: begin
        if (ld_valid) begin
          wr_en = 1'b1;
          if (wptr_q == len_q - 1'b1) next_state = S_DONE;
        end
      end
      S_DONE:  next_state = S_IDLE;
      default: next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q <= '0;
      len_q  <= '0;
    end else if (state == S_IDLE && ld_start) begin
      wptr_q <= '0;
      len_q  <= len_clamped;
    end else if (wr_en) begin
      wptr_q <= wptr_q + 1'b1;
    end
  end

  // NOTE: the array has no reset so it maps onto block RAM and a loaded
  // program survives rst_n.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wptr_q[ADDR_W-1:0]] <= ld_data;
  end

  always_comb begin
    if (BYTE_ADDR != 0) begin
      fetch_idx  = fetch_addr[ADDR_W+1:2];
      misaligned = |fetch_addr[1:0];
    end else begin
      fetch_idx  = fetch_addr[ADDR_W-1:0];
      misaligned = 1'b0;
    end
  end

  assign out_of_range = {1'b0, fetch_idx} >= DEPTH_W;
  assign fetch_bad    = misaligned || out_of_range;
  assign fetch_ready  = (state == S_IDLE) && !ld_start;
  assign fetch_acc    = fetch_req && fetch_ready;

  // Data and error only update on an accepted fetch; otherwise they hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_valid <= 1'b0;
      fetch_data  <= '0;
      fetch_err   <= 1'b0;
    end else begin
      fetch_valid <= fetch_acc;
      if (fetch_acc) begin
        fetch_err  <= fetch_bad;
        fetch_data <= fetch_bad ? NOP_WORD : mem[fetch_idx];
      end
    end
  end

  assign ld_ready = (state == S_LOAD);
  assign ld_done  = (state == S_DONE);

endmodule

// File: tb/tb_imem_loadable.sv
// Bench for imem_loadable: a word-addressed full-depth instance and a byte-addressed
// half-depth instance share stimulus and are checked against an array-based model.
module tb_imem_loadable;

  localparam logic [31:0] NOP_B = 32'h00000013;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        fetch_req = 1'b0;
  logic [11:0] fetch_addr = '0;
  logic        ld_start = 1'b0;
  logic [10:0] ld_len = '0;
  logic        ld_valid = 1'b0;
  logic [31:0] ld_data = '0;

  logic        fr [2];
  logic        fv [2];
  logic [31:0] fd [2];
  logic        fe [2];
  logic        lr [2];
  logic        ldn [2];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  imem_loadable #(.ADDR_W(10), .DATA_W(32), .DEPTH(1024), .BYTE_ADDR(0), .NOP_WORD(32'h0)) u_word (
    .clk(clk), .rst_n(rst_n), .fetch_req(fetch_req), .fetch_addr(fetch_addr),
    .fetch_ready(fr[0]), .fetch_valid(fv[0]), .fetch_data(fd[0]), .fetch_err(fe[0]),
    .ld_start(ld_start), .ld_len(ld_len), .ld_valid(ld_valid), .ld_data(ld_data),
    .ld_ready(lr[0]), .ld_done(ldn[0]));

  imem_loadable #(.ADDR_W(10), .DATA_W(32), .DEPTH(512), .BYTE_ADDR(1), .NOP_WORD(NOP_B)) u_byte (
    .clk(clk), .rst_n(rst_n), .fetch_req(fetch_req), .fetch_addr(fetch_addr),
    .fetch_ready(fr[1]), .fetch_valid(fv[1]), .fetch_data(fd[1]), .fetch_err(fe[1]),
    .ld_start(ld_start), .ld_len(ld_len), .ld_valid(ld_valid), .ld_data(ld_data),
    .ld_ready(lr[1]), .ld_done(ldn[1]));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int          m_depth [2] = '{1024, 512};
  bit          m_byte  [2] = '{1'b0, 1'b1};
  logic [31:0] m_nop   [2] = '{32'h0, NOP_B};
  logic [31:0] m_mem   [2][1024];
  bit          m_known [2][1024];
  bit          m_loading [2] = '{1'b0, 1'b0};
  bit          m_done    [2] = '{1'b0, 1'b0};
  int          m_left [2] = '{0, 0};
  int          m_wptr [2] = '{0, 0};
  bit          m_fv [2] = '{1'b0, 1'b0};
  logic [31:0] m_fd [2] = '{32'h0, 32'h0};
  bit          m_fe [2] = '{1'b0, 1'b0};
  bit          m_dknown [2] = '{1'b1, 1'b1};
  bit          t_idle, t_bad;
  int          t_idx, t_n;

  function automatic bit m_idle(input int i);
    return !m_loading[i] && !m_done[i];
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        m_loading[i] = 1'b0; m_done[i] = 1'b0; m_left[i] = 0; m_wptr[i] = 0;
        m_fv[i] = 1'b0; m_fd[i] = 32'h0; m_fe[i] = 1'b0; m_dknown[i] = 1'b1;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        t_idle  = m_idle(i);
        m_fv[i] = fetch_req && t_idle && !ld_start;
        if (m_fv[i]) begin
          t_idx = m_byte[i] ? int'(fetch_addr) / 4 : int'(fetch_addr) % 1024;
          t_bad = (m_byte[i] && (fetch_addr[1:0] != 2'b00)) || (t_idx >= m_depth[i]);
          m_fe[i] = t_bad;
          m_fd[i] = t_bad ? m_nop[i] : m_mem[i][t_idx];
          m_dknown[i] = t_bad || m_known[i][t_idx];
        end
        if (m_done[i]) begin
          m_done[i] = 1'b0;
        end else if (m_loading[i] && ld_valid) begin
          m_mem[i][m_wptr[i]]   = ld_data;
          m_known[i][m_wptr[i]] = 1'b1;
          m_wptr[i]++;
          m_left[i]--;
          if (m_left[i] == 0) begin
            m_loading[i] = 1'b0;
            m_done[i]    = 1'b1;
          end
        end
        if (t_idle && ld_start) begin
          t_n = (int'(ld_len) < m_depth[i]) ? int'(ld_len) : m_depth[i];
          m_wptr[i] = 0;
          if (t_n == 0) m_done[i] = 1'b1;
          else begin
            m_loading[i] = 1'b1;
            m_left[i]    = t_n;
          end
        end
      end
    end
  end

  // Single compare process, sampled mid-cycle away from the active edge.
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      check($sformatf("fetch_ready[%0d]", i), 32'(fr[i]), 32'(m_idle(i) && !ld_start));
      check($sformatf("fetch_valid[%0d]", i), 32'(fv[i]), 32'(m_fv[i]));
      check($sformatf("fetch_err[%0d]", i),   32'(fe[i]), 32'(m_fe[i]));
      check($sformatf("ld_ready[%0d]", i),    32'(lr[i]), 32'(m_loading[i]));
      check($sformatf("ld_done[%0d]", i),     32'(ldn[i]), 32'(m_done[i]));
      if (m_dknown[i]) check($sformatf("fetch_data[%0d]", i), fd[i], m_fd[i]);
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  localparam logic [31:0] W0 = 32'h20110001;
  localparam logic [31:0] W1 = 32'h08000c05;
  localparam logic [31:0] W2 = 32'h0000000c;

  initial begin
    int          k_done_b, k_done_w;
    logic [31:0] seq_w [4];
    logic [31:0] a_new, b_new, r0, r1;
    logic [31:0] exp_rst [4];

    #1 rst_n = 1'b0;
    tick(); tick();
    check("reset_fetch_valid", 32'(fv[0]), 32'h0);
    check("reset_fetch_data",  fd[1], 32'h0);
    check("reset_ld_ready",    32'(lr[0]), 32'h0);
    rst_n = 1'b1;
    #1 check("reset_fetch_ready", 32'(fr[0] && fr[1]), 32'h1);

    // Preload: fills the word instance fully, exercises the 512-word clamp on the byte one.
    k_done_b = -1; k_done_w = -1;
    ld_start = 1'b1; ld_len = 11'd1024;
    tick();
    ld_start = 1'b0; ld_valid = 1'b1;
    for (int k = 0; k < 1100; k++) begin
      ld_data = $urandom;
      tick();
      if (k_done_b >= 0 && k == k_done_b + 1) check("clamp_ld_ready_low", 32'(lr[1]), 32'h0);
      if (ldn[1] && k_done_b < 0) k_done_b = k;
      if (ldn[0]) begin
        k_done_w = k;
        break;
      end
    end
    ld_valid = 1'b0;
    check("clamp_done_after_512", 32'(k_done_b), 32'd511);
    check("full_done_after_1024", 32'(k_done_w), 32'd1023);
    tick();

    // Three-word program: start edge, three write edges, then the DONE cycle.
    ld_start = 1'b1; ld_len = 11'd3;
    tick();
    ld_start = 1'b0; ld_valid = 1'b1;
    ld_data = W0; tick();
    ld_data = W1; tick();
    check("no_done_before_last_word", 32'(ldn[0]), 32'h0);
    ld_data = W2; tick();
    ld_valid = 1'b0;
    check("done_after_len_writes", 32'(ldn[0] && ldn[1]), 32'h1);
    tick();
    check("done_one_cycle", 32'(ldn[0]), 32'h0);

    // Back-to-back fetch 0,1,2,0 in word mode.
    seq_w = '{W0, W1, W2, W0};
    fetch_req = 1'b1;
    for (int j = 0; j < 4; j++) begin
      fetch_addr = (j == 3) ? 12'd0 : 12'(j);
      tick();
      check($sformatf("b2b_valid_%0d", j), 32'(fv[0]), 32'h1);
      check($sformatf("b2b_data_%0d", j), fd[0], seq_w[j]);
      check($sformatf("b2b_err_%0d", j), 32'(fe[0]), 32'h0);
    end
    fetch_req = 1'b0;
    tick();
    check("valid_drops", 32'(fv[0]), 32'h0);
    check("data_holds", fd[0], W0);

    // Byte-address error cases on the 512-word instance.
    fetch_req = 1'b1; fetch_addr = 12'h006; tick();
    check("byte_misaligned_err", 32'(fe[1]), 32'h1);
    check("byte_misaligned_nop", fd[1], NOP_B);
    fetch_addr = 12'h800; tick();
    check("byte_out_of_range_err", 32'(fe[1]), 32'h1);
    fetch_addr = 12'h004; tick();
    check("byte_word1_err", 32'(fe[1]), 32'h0);
    check("byte_word1_data", fd[1], W1);
    fetch_req = 1'b0; tick();

    // Collision with a zero-length load: fetch held, served after the DONE cycle.
    fetch_req = 1'b1; fetch_addr = 12'd1; ld_start = 1'b1; ld_len = 11'd0;
    #1 check("collision_ready_low", 32'(fr[0] || fr[1]), 32'h0);
    tick();
    ld_start = 1'b0;
    check("zero_len_done", 32'(ldn[0]), 32'h1);
    check("collision_no_valid", 32'(fv[0]), 32'h0);
    tick();
    check("zero_len_done_clears", 32'(ldn[0]), 32'h0);
    tick();
    check("collision_served", 32'(fv[0]), 32'h1);
    check("zero_len_no_change", fd[0], W1);

    // Collision with a two-word load: the held fetch returns the new word 0.
    a_new = $urandom; b_new = $urandom;
    fetch_addr = 12'd0; ld_start = 1'b1; ld_len = 11'd2;
    tick();
    ld_start = 1'b0; ld_valid = 1'b1;
    ld_data = a_new; tick();
    ld_data = b_new; tick();
    ld_valid = 1'b0;
    check("coll_load_done", 32'(ldn[0]), 32'h1);
    tick();
    check("coll_load_no_valid", 32'(fv[0]), 32'h0);
    tick();
    check("coll_load_served", 32'(fv[0]), 32'h1);
    check("coll_load_new_word", fd[0], a_new);
    fetch_req = 1'b0; tick();

    // Reset in the middle of a four-word load.
    exp_rst[3] = m_mem[0][3];
    r0 = $urandom; r1 = $urandom;
    ld_start = 1'b1; ld_len = 11'd4;
    tick();
    ld_start = 1'b0; ld_valid = 1'b1;
    ld_data = r0; tick();
    ld_data = r1; tick();
    rst_n = 1'b0; ld_valid = 1'b0;
    #1 check("midload_reset_ready_low", 32'(lr[0]), 32'h0);
    tick(); tick();
    rst_n = 1'b1;
    #1 check("midload_release_ready", 32'(fr[0]), 32'h1);
    exp_rst[0] = r0; exp_rst[1] = r1; exp_rst[2] = W2;
    fetch_req = 1'b1;
    for (int j = 0; j < 4; j++) begin
      fetch_addr = 12'(j);
      tick();
      check($sformatf("midload_no_done_%0d", j), 32'(ldn[0]), 32'h0);
      check($sformatf("midload_word_%0d", j), fd[0], exp_rst[j]);
    end
    fetch_req = 1'b0; tick();

    // Randomised traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      fetch_req  = ($urandom_range(0, 3) != 0);
      fetch_addr = 12'($urandom);
      ld_start   = ($urandom_range(0, 49) == 0);
      ld_len     = ($urandom_range(0, 7) == 0) ? 11'($urandom_range(500, 1100))
                                               : 11'($urandom_range(0, 6));
      ld_valid   = ($urandom_range(0, 2) != 0);
      ld_data    = $urandom;
      if ($urandom_range(0, 599) == 0) rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
    end
    fetch_req = 1'b0; ld_start = 1'b0; ld_valid = 1'b0;
    tick(); tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
